flag_board: RTL and testbench

Flag-state store for the 16x16 Minesweeper board. It holds one flag bit per cell and toggles the bit under the cursor on a player request, refusing the toggle on revealed cells or when the flag budget is spent. It keeps a running flag count and clears the board on a new-game request. It sits directly upstream of the flag renderer and supplies that renderer's per-pixel `flag_here` lookup from the current VGA scan position.

---
 rtl/flag_board.sv | 235 +++++++++++++++++++++++
 tb/tb_flag_board.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_board.sv
// flag_board
// -----------------------------------------------------------------------------
// Flag-state store for a GRID_W x GRID_H Minesweeper board. One flag bit per
// cell. A player toggle request flips the bit under the cursor, unless the cell
// is revealed or the flag budget is spent. The block keeps a running flag count,
// sweeps the board clear on a new-game request, and answers a zero-latency
// "is the cell under the scan position flagged" lookup for the flag renderer.
//
// Ports
//   clk           system/pixel clock, rising edge
//   rst           asynchronous active-low reset
//   cur_x/cur_y   cursor column/row (4 bits each)
//   cur_revealed  cell at the cursor is revealed
//   game_active   toggles are accepted only while high
//   toggle_req    level request: toggle the flag at the cursor
//   clear_req     level request: clear every flag (new game)
//   xPixel/yPixel current scan position (10 bits each)
//   active_pixels scan is inside the visible area
//   flag_here     combinational: cell under the scan position is flagged
//   flag_count    number of flags currently set (9 bits)
//   busy          controller is not idle
//   toggle_done   one-cycle pulse: toggle applied
//   toggle_rej    one-cycle pulse: toggle refused
//   clear_done    one-cycle pulse: clear sweep finished
// -----------------------------------------------------------------------------
module flag_board #(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 16,
  parameter int CELL_W    = 40,
  parameter int CELL_H    = 30,
  parameter int MAX_FLAGS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cur_x,
  input  logic [3:0] cur_y,
  input  logic       cur_revealed,
  input  logic       game_active,
  input  logic       toggle_req,
  input  logic       clear_req,
  input  logic [9:0] xPixel,
  input  logic [9:0] yPixel,
  input  logic       active_pixels,
  output logic       flag_here,
  output logic [8:0] flag_count,
  output logic       busy,
  output logic       toggle_done,
  output logic       toggle_rej,
  output logic       clear_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t     state_reg, state_next;

  logic [3:0] lat_x_reg, lat_y_reg;
  logic       lat_rev_reg;
  logic [3:0] row_cnt_reg;
  logic [8:0] count_reg, count_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       rej_reg, rej_next;
  logic       cdone_reg, cdone_next;

  logic       latch_en;
  logic       wr_en;
  logic       clr_row_en;
  logic       cur_bit;

  // Packed view of all row registers, used by both the toggle path and the
  // pixel lookup.
  logic [GRID_H-1:0][GRID_W-1:0] flags;

  // ---------------------------------------------------------------------------
  // Flag storage: one register per row. A row is either zeroed by the clear
  // sweep or has a single bit inverted by a toggle; the two never coincide
  // because they belong to different controller states.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < GRID_H; gi++) begin : g_row
      logic [GRID_W-1:0] row_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          row_reg <= '0;
        end else if (clr_row_en && (row_cnt_reg == 4'(gi))) begin
          row_reg <= '0;
        end else if (wr_en && (lat_y_reg == 4'(gi))) begin
          row_reg[lat_x_reg] <= ~row_reg[lat_x_reg];
        end
      end

      assign flags[gi] = row_reg;
    end
  endgenerate

  assign cur_bit = flags[lat_y_reg][lat_x_reg];

  // ---------------------------------------------------------------------------
  // Controller: state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      lat_x_reg   <= '0;
      lat_y_reg   <= '0;
      lat_rev_reg <= 1'b0;
      row_cnt_reg <= '0;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      rej_reg     <= 1'b0;
      cdone_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      rej_reg   <= rej_next;
      cdone_reg <= cdone_next;
      if (latch_en) begin
        lat_x_reg   <= cur_x;
        lat_y_reg   <= cur_y;
        lat_rev_reg <= cur_revealed;
      end
      // The sweep counter idles at zero so every clear starts at row 0,
      // including one that aborts a toggle.
      if (state_reg == CLEAR) begin
        row_cnt_reg <= row_cnt_reg + 4'd1;
      end else begin
        row_cnt_reg <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Controller: next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    rej_next   = 1'b0;
    cdone_next = 1'b0;
    latch_en   = 1'b0;
    wr_en      = 1'b0;
    clr_row_en = 1'b0;

    case (state_reg)
      IDLE: begin
        // Clear has priority over a simultaneous toggle.
        if (clear_req) begin
          state_next = CLEAR;
        end else if (toggle_req && game_active) begin
          state_next = CHECK;
          latch_en   = 1'b1;
        end
      end

      CHECK: begin
        if (clear_req) begin
          state_next = CLEAR;
        end else if (lat_rev_reg ||
                     (!cur_bit && (count_reg == 9'(MAX_FLAGS)))) begin
          rej_next   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = WRITE;
        end
      end

      WRITE: begin
        if (clear_req) begin
          state_next = CLEAR;
        end else begin
          wr_en      = 1'b1;
          // CHECK has already excluded overflow, so no saturation is needed.
          count_next = cur_bit ? (count_reg - 9'd1) : (count_reg + 9'd1);
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      CLEAR: begin
        clr_row_en = 1'b1;
        if (row_cnt_reg == 4'(GRID_H - 1)) begin
          cdone_next = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // The count drops to zero on the edge that enters the sweep.
    if ((state_next == CLEAR) && (state_reg != CLEAR)) begin
      count_next = '0;
    end
  end

  assign busy_next = (state_next != IDLE);

  // ---------------------------------------------------------------------------
  // Pixel lookup: scan position -> cell -> flag bit, zero latency. The board
  // is masked during the sweep so partially cleared rows never reach the
  // screen.
  // ---------------------------------------------------------------------------
  logic [9:0] x_cell, y_cell;

  assign x_cell = xPixel / 10'(CELL_W);
  assign y_cell = yPixel / 10'(CELL_H);

  always_comb begin
    flag_here = 1'b0;
    if (active_pixels && (x_cell < 10'(GRID_W)) && (y_cell < 10'(GRID_H)) &&
        (state_reg != CLEAR)) begin
      flag_here = flags[y_cell[3:0]][x_cell[3:0]];
    end
  end

  assign flag_count  = count_reg;
  assign busy        = busy_reg;
  assign toggle_done = done_reg;
  assign toggle_rej  = rej_reg;
  assign clear_done  = cdone_reg;

endmodule

// File: tb/tb_flag_board.sv
module tb_flag_board;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cur_x = 4'd0;
  logic [3:0] cur_y = 4'd0;
  logic       cur_revealed = 1'b0;
  logic       game_active = 1'b1;
  logic       toggle_req = 1'b0;
  logic       clear_req = 1'b0;
  logic [9:0] xPixel = 10'd0;
  logic [9:0] yPixel = 10'd0;
  logic       active_pixels = 1'b1;
  logic       flag_here;
  logic [8:0] flag_count;
  logic       busy;
  logic       toggle_done;
  logic       toggle_rej;
  logic       clear_done;

  flag_board dut (
    .clk           (clk),
    .rst           (rst),
    .cur_x         (cur_x),
    .cur_y         (cur_y),
    .cur_revealed  (cur_revealed),
    .game_active   (game_active),
    .toggle_req    (toggle_req),
    .clear_req     (clear_req),
    .xPixel        (xPixel),
    .yPixel        (yPixel),
    .active_pixels (active_pixels),
    .flag_here     (flag_here),
    .flag_count    (flag_count),
    .busy          (busy),
    .toggle_done   (toggle_done),
    .toggle_rej    (toggle_rej),
    .clear_done    (clear_done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a board of bits plus a count, and a timeline of how many
  // cycles remain in the current operation. The outcome of a toggle is decided
  // from the rules at acceptance; its effect lands when the timeline runs out.
  // A clear wipes the model board at once, since the lookup is masked anyway
  // until the sweep finishes.
  // ---------------------------------------------------------------------------
  bit m_flags[16][16];
  int m_count      = 0;
  int m_clear_left = 0;
  int m_tog_left   = 0;
  int m_tx = 0, m_ty = 0;
  bit m_ok = 1'b0;
  bit m_done = 1'b0, m_rej = 1'b0, m_cdone = 1'b0;

  task m_start_clear();
    m_clear_left = 16;
    m_tog_left   = 0;
    m_count      = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        m_flags[a][b] = 1'b0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_start_clear();
      m_clear_left = 0;
      m_done = 1'b0; m_rej = 1'b0; m_cdone = 1'b0;
    end else begin
      m_done = 1'b0; m_rej = 1'b0; m_cdone = 1'b0;
      if (m_clear_left > 0) begin
        m_clear_left--;
        if (m_clear_left == 0) m_cdone = 1'b1;
      end else if (m_tog_left > 0 && clear_req) begin
        m_start_clear();
      end else if (m_tog_left > 0) begin
        m_tog_left--;
        if (m_tog_left == 0) begin
          if (m_ok) begin
            m_count = m_flags[m_ty][m_tx] ? m_count - 1 : m_count + 1;
            m_flags[m_ty][m_tx] = !m_flags[m_ty][m_tx];
            m_done = 1'b1;
          end else begin
            m_rej = 1'b1;
          end
        end
      end else if (clear_req) begin
        m_start_clear();
      end else if (toggle_req && game_active) begin
        m_tx = int'(cur_x);
        m_ty = int'(cur_y);
        m_ok = !cur_revealed && !(!m_flags[m_ty][m_tx] && m_count == 40);
        m_tog_left = m_ok ? 2 : 1;
      end
    end
  end

  function automatic bit m_flag_here();
    int xc, yc;
    xc = int'(xPixel) / 40;
    yc = int'(yPixel) / 30;
    if (!active_pixels || xc >= 16 || yc >= 16 || m_clear_left > 0) return 1'b0;
    return m_flags[yc][xc];
  endfunction

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    chk("cyc_flag_count",  int'(flag_count),  m_count);
    chk("cyc_busy",        int'(busy),        int'(m_clear_left > 0 || m_tog_left > 0));
    chk("cyc_toggle_done", int'(toggle_done), int'(m_done));
    chk("cyc_toggle_rej",  int'(toggle_rej),  int'(m_rej));
    chk("cyc_clear_done",  int'(clear_done),  int'(m_cdone));
    chk("cyc_flag_here",   int'(flag_here),   int'(m_flag_here()));
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task tick();
    @(posedge clk);
    #1;
  endtask

  // result: 1 = done, 2 = refused, 0 = nothing seen. lat counts edges after
  // the accepting edge.
  task automatic do_toggle(input int x, input int y, input bit rev,
                           output int result, output int lat);
    cur_x = 4'(x); cur_y = 4'(y); cur_revealed = rev;
    toggle_req = 1'b1;
    tick();
    toggle_req = 1'b0;
    result = 0; lat = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (toggle_done) begin result = 1; lat = i; break; end
      if (toggle_rej)  begin result = 2; lat = i; break; end
    end
    if (result == 0) chk("toggle_timeout", 0, 1);
    $display("toggle (%0d,%0d) rev=%0d -> %s after %0d edges, count=%0d",
             x, y, rev, (result == 1) ? "done" : (result == 2) ? "refused" : "none",
             lat, flag_count);
  endtask

  task automatic do_clear(input bit with_toggle, output int busy_cycles,
                          output int saw_tog, output int saw_cdone);
    clear_req = 1'b1; toggle_req = with_toggle;
    tick();
    clear_req = 1'b0; toggle_req = 1'b0;
    busy_cycles = 0; saw_tog = 0; saw_cdone = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cycles++;
      if (toggle_done || toggle_rej) saw_tog = 1;
      if (clear_done) begin saw_cdone = 1; break; end
      tick();
    end
    $display("clear (with toggle=%0d) -> busy %0d cycles, done=%0d, count=%0d",
             with_toggle, busy_cycles, saw_cdone, flag_count);
  endtask

  task automatic set_pixel(input int x, input int y);
    xPixel = 10'(x); yPixel = 10'(y);
    #1;
  endtask

  initial begin
    int r, l, bc, st, cd;

    // Reset
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_flag_count", int'(flag_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({toggle_done, toggle_rej, clear_done}), 0);
    rst = 1'b1;
    tick();

    // Set (3,5) and look it up at two pixels inside the cell
    do_toggle(3, 5, 1'b0, r, l);
    chk("t1_result", r, 1);
    chk("t1_latency", l, 2);
    chk("t1_count", int'(flag_count), 1);
    set_pixel(125, 155); chk("t1_pix_125_155", int'(flag_here), 1);
    set_pixel(120, 155); chk("t1_pix_120_155", int'(flag_here), 1);
    set_pixel(119, 155); chk("t1_pix_119_155", int'(flag_here), 0);

    // Clear it again, then try a revealed cell
    do_toggle(3, 5, 1'b0, r, l);
    chk("t2_result", r, 1);
    chk("t2_count", int'(flag_count), 0);
    set_pixel(125, 155); chk("t2_pix", int'(flag_here), 0);
    do_toggle(3, 5, 1'b1, r, l);
    chk("t3_result", r, 2);
    chk("t3_latency", l, 1);
    chk("t3_count", int'(flag_count), 0);
    chk("t3_pix", int'(flag_here), 0);

    // Spend the whole budget
    for (int i = 0; i < 40; i++) do_toggle(i % 16, i / 16, 1'b0, r, l);
    chk("t4_count40", int'(flag_count), 40);
    do_toggle(8, 2, 1'b0, r, l);
    chk("t4_41st_result", r, 2);
    chk("t4_41st_count", int'(flag_count), 40);
    do_toggle(0, 0, 1'b0, r, l);
    chk("t4_unflag_result", r, 1);
    chk("t4_unflag_count", int'(flag_count), 39);
    set_pixel(10, 10);  chk("t4_pix_0_0", int'(flag_here), 0);
    set_pixel(330, 70); chk("t4_pix_8_2", int'(flag_here), 0);
    set_pixel(45, 5);   chk("t4_pix_1_0", int'(flag_here), 1);

    // Plain clear, then clear racing a toggle with 10 flags set
    do_clear(1'b0, bc, st, cd);
    chk("t5_count", int'(flag_count), 0);
    for (int i = 0; i < 10; i++) do_toggle(i, 0, 1'b0, r, l);
    chk("t6_count10", int'(flag_count), 10);
    set_pixel(45, 5);   // stays on a flagged cell during the sweep
    cur_x = 4'd12; cur_y = 4'd0; cur_revealed = 1'b0;
    do_clear(1'b1, bc, st, cd);
    chk("t6_busy_cycles", bc, 16);
    chk("t6_no_toggle_pulse", st, 0);
    chk("t6_clear_done", cd, 1);
    chk("t6_count", int'(flag_count), 0);
    chk("t6_pix_1_0", int'(flag_here), 0);

    // Clear arriving while the toggle sits in CHECK aborts it
    cur_x = 4'd2; cur_y = 4'd2; cur_revealed = 1'b0;
    toggle_req = 1'b1;
    tick();
    toggle_req = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    st = 0; cd = 0;
    for (int i = 0; i < 30; i++) begin
      if (toggle_done || toggle_rej) st = 1;
      if (clear_done) begin cd = 1; break; end
      tick();
    end
    $display("toggle (2,2) aborted by clear -> clear done=%0d, count=%0d", cd, flag_count);
    chk("t7_no_toggle_pulse", st, 0);
    chk("t7_clear_done", cd, 1);
    set_pixel(85, 65); chk("t7_pix_2_2", int'(flag_here), 0);

    // Reset in the middle of a sweep
    do_toggle(4, 4, 1'b0, r, l);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    $display("reset during clear -> busy=%0d count=%0d", busy, flag_count);
    chk("t8_rst_busy", int'(busy), 0);
    chk("t8_rst_count", int'(flag_count), 0);
    chk("t8_rst_cdone", int'(clear_done), 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    set_pixel(165, 125); chk("t8_pix_4_4", int'(flag_here), 0);

    // Lookup bounds at the far corner
    do_toggle(15, 15, 1'b0, r, l);
    chk("t9_result", r, 1);
    set_pixel(639, 479); chk("t9_pix_639_479", int'(flag_here), 1);
    set_pixel(640, 479); chk("t9_pix_640_479", int'(flag_here), 0);
    set_pixel(639, 480); chk("t9_pix_639_480", int'(flag_here), 0);
    set_pixel(639, 479);
    active_pixels = 1'b0;
    #1 chk("t9_inactive", int'(flag_here), 0);
    active_pixels = 1'b1;

    // Toggle request while the game is not active is ignored
    game_active = 1'b0;
    cur_x = 4'd1; cur_y = 4'd1;
    toggle_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t10_busy", int'(busy), 0);
      chk("t10_pulse", int'(toggle_done | toggle_rej), 0);
    end
    toggle_req = 1'b0;
    $display("toggle (1,1) with game inactive -> ignored, count=%0d", flag_count);
    tick();
    game_active = 1'b1;
    tick();
    chk("t10_count", int'(flag_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
